// File: rtl/chunked_add_sub_unit_if.sv
// Operand/result bundle for chunked_add_sub_unit.
//   master : requester; drives start, mode, a, b, carry_in and observes status/result.
//   slave  : the arithmetic unit; receives the request and drives busy, done, sum and flags.
// WIDTH must match the WIDTH of the unit the interface is connected to.
interface chunked_add_sub_unit_if #(
  parameter int unsigned WIDTH = 32
);

  // Request side
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;

  // Status / result side
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start,
    output mode,
    output a,
    output b,
    output carry_in,
    input  busy,
    input  done,
    input  sum,
    input  carry_out,
    input  overflow,
    input  zero
  );

  modport slave (
    input  start,
    input  mode,
    input  a,
    input  b,
    input  carry_in,
    output busy,
    output done,
    output sum,
    output carry_out,
    output overflow,
    output zero
  );

endinterface

// File: rtl/chunked_add_sub_unit.sv
// Multi-cycle adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock,
// holding the inter-slice carry in a register.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of chunked_add_sub_unit_if
//            start    - request pulse, operands sampled on the same edge (ignored while busy)
//            mode     - 0 = a + b + carry_in, 1 = a - b (a + ~b + 1, carry_in ignored)
//            a, b     - operands
//            carry_in - carry into bit 0 (add only)
//            busy     - high while slices are being processed
//            done     - one-cycle pulse when sum/flags have just been updated
//            sum      - result register (mod 2^WIDTH), holds until the next completion
//            carry_out- carry out of the MSB (subtract: 1 = no borrow)
//            overflow - signed two's-complement overflow
//            zero     - sum == 0
//
// Latency: start sampled at edge k -> busy after edges k..k+N-1 -> done after edge k+N,
// where N = WIDTH/CHUNK. Asserting start during the done cycle chains the next operation.
module chunked_add_sub_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_add_sub_unit_if.slave bus
);

  localparam int unsigned NumSlices = WIDTH / CHUNK;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;   // b, already inverted for subtract
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  // ---------------------------------------------------------------------------
  // Slice datapath
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   slice_res;     // {carry, CHUNK-bit sum}
  logic [WIDTH-1:0] psum_merged;   // partial sum with the current slice written in
  logic             last_slice;
  logic             result_ovf;
  logic             result_zero;

  always_comb begin
    a_slice     = '0;
    b_slice     = '0;
    // Constant-index mux keeps the slice select free of variable part-selects.
    for (int unsigned i = 0; i < NumSlices; i++) begin
      if (cnt_q == CntW'(i)) begin
        a_slice = op_a_q[i*CHUNK +: CHUNK];
        b_slice = op_b_q[i*CHUNK +: CHUNK];
      end
    end

    slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};

    psum_merged = psum_q;
    for (int unsigned i = 0; i < NumSlices; i++) begin
      if (cnt_q == CntW'(i)) begin
        psum_merged[i*CHUNK +: CHUNK] = slice_res[CHUNK-1:0];
      end
    end

    last_slice  = (cnt_q == LastCnt);
    // Operands share a sign but the result does not: signed overflow.
    result_ovf  = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                  (psum_merged[WIDTH-1] != op_a_q[WIDTH-1]);
    result_zero = (psum_merged == '0);
  end

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    psum_d      = psum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.mode ? ~bus.b : bus.b;
          // Subtract is a + ~b + 1, so the +1 enters as the initial carry.
          carry_d = bus.mode ? 1'b1 : bus.carry_in;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end

      StRun: begin
        psum_d  = psum_merged;
        carry_d = slice_res[CHUNK];
        cnt_d   = cnt_q + CntW'(1);
        if (last_slice) begin
          sum_d       = psum_merged;
          carry_out_d = slice_res[CHUNK];
          overflow_d  = result_ovf;
          zero_d      = result_zero;
          state_d     = StDone;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      psum_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b1;   // sum resets to 0, so the flag starts set
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      psum_q      <= psum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_chunked_add_sub_unit.sv
// Bench for chunked_add_sub_unit: a scoreboarded 32/8 instance plus 16/4 and 16/16 instances
// driven in lockstep for the latency sweep.
module tb_chunked_add_sub_unit;

  localparam int unsigned W = 32;
  localparam int unsigned C = 8;
  localparam int N = W / C;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          k;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic        cin;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } dir_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q[$];
  exp_t held;

  chunked_add_sub_unit_if #(.WIDTH(32)) bus32 ();
  chunked_add_sub_unit_if #(.WIDTH(16)) bus4 ();
  chunked_add_sub_unit_if #(.WIDTH(16)) bus16 ();

  chunked_add_sub_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  chunked_add_sub_unit #(.WIDTH(16), .CHUNK(4)) dut_w16_c4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  chunked_add_sub_unit #(.WIDTH(16), .CHUNK(16)) dut_w16_c16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit machine.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic mode, input logic cin);
    exp_t   r;
    longint full, half, ua, ub, sa, sb, ur, sr;
    full = 64'sd1 << w;
    half = full / 2;
    ua   = longint'({32'h0, a}) & (full - 1);
    ub   = longint'({32'h0, b}) & (full - 1);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    if (mode) begin
      ur     = ua - ub;
      sr     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      ur     = ua + ub + longint'(cin);
      sr     = sa + sb + longint'(cin);
      r.cout = (ur >= full);
    end
    r.sum  = 32'(ur & (full - 1));
    r.zero = ((ur & (full - 1)) == 0);
    r.ovf  = (sr > half - 1) || (sr < -half);
    r.k    = 0;
    return r;
  endfunction

  function automatic exp_t reset_exp();
    exp_t r;
    r.sum = '0; r.cout = 1'b0; r.ovf = 1'b0; r.zero = 1'b1; r.k = 0;
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: busy window, done timing, result compare and output hold.
  always @(negedge clk) begin
    logic exp_busy;
    exp_t e;
    exp_busy = (q.size() > 0) && (cyc < q[0].k + N);
    chk("busy", bus32.busy, exp_busy);
    if (bus32.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", bus32.done, 1'b0);
      end else begin
        e = q.pop_front();
        chk("done_latency", cyc, e.k + N);
        chk("sum", bus32.sum, e.sum);
        chk("carry_out", bus32.carry_out, e.cout);
        chk("overflow", bus32.overflow, e.ovf);
        chk("zero", bus32.zero, e.zero);
        held = e;
      end
    end else begin
      if (q.size() > 0 && cyc >= q[0].k + N) begin
        chk("done_at_latency", bus32.done, 1'b1);
        void'(q.pop_front());
      end
      chk("hold_sum", bus32.sum, held.sum);
      chk("hold_flags", {bus32.carry_out, bus32.overflow, bus32.zero},
          {held.cout, held.ovf, held.zero});
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic mode,
                       input logic cin, input exp_t e);
    exp_t t;
    @(negedge clk);
    bus32.a        = a;
    bus32.b        = b;
    bus32.mode     = mode;
    bus32.carry_in = cin;
    bus32.start    = 1'b1;
    @(posedge clk);
    #1;
    t   = e;
    t.k = cyc;
    q.push_back(t);
    bus32.start    = 1'b0;
    // Only latched values may matter from here on.
    bus32.a        = $urandom;
    bus32.b        = $urandom;
    bus32.mode     = 1'($urandom);
    bus32.carry_in = 1'($urandom);
  endtask

  // A start pulse while the unit is busy; must be ignored.
  task automatic spurious_start();
    @(negedge clk);
    bus32.a        = $urandom;
    bus32.b        = $urandom;
    bus32.mode     = 1'($urandom);
    bus32.carry_in = 1'($urandom);
    bus32.start    = 1'b1;
    @(posedge clk);
    #1;
    bus32.start    = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic run_small(input logic [15:0] a, input logic [15:0] b, input logic mode,
                           input logic cin, input exp_t e);
    int s0, lat4, lat16;
    logic got4, got16;
    logic [18:0] r4, r16;
    got4 = 1'b0; got16 = 1'b0; lat4 = -1; lat16 = -1; r4 = '0; r16 = '0;
    @(negedge clk);
    bus4.a  = a; bus4.b  = b; bus4.mode  = mode; bus4.carry_in  = cin; bus4.start  = 1'b1;
    bus16.a = a; bus16.b = b; bus16.mode = mode; bus16.carry_in = cin; bus16.start = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    bus4.start  = 1'b0;
    bus16.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus4.done && !got4) begin
        got4 = 1'b1; lat4 = cyc - s0;
        r4 = {bus4.sum, bus4.carry_out, bus4.overflow, bus4.zero};
      end
      if (bus16.done && !got16) begin
        got16 = 1'b1; lat16 = cyc - s0;
        r16 = {bus16.sum, bus16.carry_out, bus16.overflow, bus16.zero};
      end
    end
    chk("w16c4_done", got4, 1'b1);
    chk("w16c4_latency", 64'(lat4), 64'd4);
    chk("w16c4_result", r4, {e.sum[15:0], e.cout, e.ovf, e.zero});
    chk("w16c16_done", got16, 1'b1);
    chk("w16c16_latency", 64'(lat16), 64'd1);
    chk("w16c16_result", r16, {e.sum[15:0], e.cout, e.ovf, e.zero});
  endtask

  dir_t dir[8] = '{
    '{32'h5AD76D6B, 32'h30D64F61, 1'b0, 1'b0, 32'h8BADBCCC, 1'b0, 1'b1, 1'b0},
    '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0},
    '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0},
    '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0},
    '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0},
    '{32'h00001234, 32'h00001234, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1},
    '{32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    logic rm, rc;
    int g, rem;

    held = reset_exp();
    bus32.start = 1'b0; bus32.mode = 1'b0; bus32.a = '0; bus32.b = '0; bus32.carry_in = 1'b0;
    bus4.start  = 1'b0; bus4.mode  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.carry_in  = 1'b0;
    bus16.start = 1'b0; bus16.mode = 1'b0; bus16.a = '0; bus16.b = '0; bus16.carry_in = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-computed results.
    foreach (dir[i]) begin
      e.sum = dir[i].s; e.cout = dir[i].c; e.ovf = dir[i].o; e.zero = dir[i].z; e.k = 0;
      issue(dir[i].a, dir[i].b, dir[i].mode, dir[i].cin, e);
      wait_idle();
    end

    // Starts while busy are dropped; exactly one done follows.
    issue(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, model(32, 32'h1000, 32'h234, 1'b0, 1'b0));
    spurious_start();
    spurious_start();
    wait_idle();

    // Chained operations: start held during the done cycle.
    issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1,
          model(32, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1));
    repeat (N) @(posedge clk);
    issue(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, model(32, 32'h0, 32'h1, 1'b1, 1'b0));
    repeat (N) @(posedge clk);
    issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0,
          model(32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0));
    wait_idle();

    // Asynchronous reset in the middle of an operation.
    issue(32'h0F0F_0F0F, 32'h1234_5678, 1'b0, 1'b0,
          model(32, 32'h0F0F_0F0F, 32'h1234_5678, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    held = reset_exp();
    #1;
    chk("rst_busy", bus32.busy, 1'b0);
    chk("rst_done", bus32.done, 1'b0);
    chk("rst_sum", bus32.sum, 32'h0);
    chk("rst_zero", bus32.zero, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 3) @(posedge clk);
    issue(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, model(32, 32'h3, 32'h4, 1'b0, 1'b0));
    wait_idle();

    // Randomized traffic with random gaps (gap 0 = back-to-back).
    for (int i = 0; i < 150; i++) begin
      ra = pick(); rb = pick(); rm = 1'($urandom); rc = 1'($urandom);
      issue(ra, rb, rm, rc, model(32, ra, rb, rm, rc));
      g = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) begin
        spurious_start();
        rem = N - 1 + g;
      end else begin
        rem = N + g;
      end
      repeat (rem) @(posedge clk);
    end
    wait_idle();

    // Width/chunk sweep on the 16-bit instances.
    e.sum = 32'h0000_8000; e.cout = 1'b0; e.ovf = 1'b1; e.zero = 1'b0; e.k = 0;
    run_small(16'h7FFF, 16'h0001, 1'b0, 1'b0, e);
    for (int i = 0; i < 20; i++) begin
      ra = 32'($urandom_range(0, 16'hFFFF));
      rb = 32'($urandom_range(0, 16'hFFFF));
      rm = 1'($urandom); rc = 1'($urandom);
      run_small(ra[15:0], rb[15:0], rm, rc, model(16, ra, rb, rm, rc));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunked_add_sub_unit.md
Name: chunked_add_sub_unit

Overview:
- Parametrised multi-cycle adder/subtractor; generalises the 32-bit ripple full adder in the ALU datapath.
- Processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock. Carry is held in a register between slices.
- Adds a subtract mode, signed overflow, a zero flag, and a start/busy/done handshake.
- Serves as the arithmetic engine for the planned multi-cycle datapath, and as an area-reduced adder where single-cycle timing is not required.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥2.
- CHUNK, 8, bits processed per cycle; must divide WIDTH exactly. CHUNK=WIDTH gives 1-cycle operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; operands are sampled on the same edge
- mode  input  1  0 = add (a+b+carry_in); 1 = subtract (a−b, computed as a+~b+1; carry_in ignored)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  carry into bit 0; add mode only
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  WIDTH  result register
- carry_out  output  1  carry out of MSB; in subtract mode 1 = no borrow
- overflow  output  1  signed two's-complement overflow
- zero  output  1  sum == 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, sum=0, carry_out=0, overflow=0, zero=1.
  - Internal operand, partial-sum, carry and slice-counter registers cleared.
- Number of slices: N = WIDTH/CHUNK. Slice counter is ceil(log2(N)) bits, minimum 1.
- IDLE / DONE, on a clk edge with start=1:
  - Latch a, and either b (mode=0) or ~b (mode=1).
  - Initial carry = carry_in (mode=0) or 1 (mode=1). Counter = 0. Go to RUN.
- RUN, on each edge:
  - Slice i (bits i*CHUNK+CHUNK−1 : i*CHUNK) = A_i + B_i + carry.
  - Write the slice into the partial-sum register; store the slice carry-out.
  - Increment the counter.
  - On the slice with i = N−1:
    - Load sum from the full partial result.
    - carry_out = final carry.
    - overflow = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]), where B' is the latched, possibly inverted, b.
    - zero = (full result == 0).
    - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE, unless start=1 in DONE, which goes directly to RUN.
- busy=1 exactly while in RUN.
- Latency:
  - start sampled at edge k; busy=1 after edges k … k+N−1.
  - sum/flags update and done=1 after edge k+N.
  - Back-to-back throughput: one result every N+1 cycles.
- start while in RUN is ignored: no effect on the operation in flight, not queued.
- a, b, mode and carry_in may change freely after the start edge; only the latched values are used.
- sum and the flags hold their previous values during RUN and change only at completion. They hold indefinitely afterwards until the next completion or reset.
- Reset mid-operation aborts immediately. Outputs return to reset values and no done is produced.
- Wrap-around: the result is modulo 2^WIDTH, and the carry is reported only via carry_out.

Test Plan:
1. WIDTH=32, CHUNK=8, add: a=0x5AD76D6B, b=0x30D64F61, cin=0 → after 4 busy cycles, done; sum=0x8BADBCCC, carry_out=0, overflow=1, zero=0.
2. Add: a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, carry_out=1, zero=1, overflow=0. Then a=b=0xFFFFFFFF, cin=1 → sum=0xFFFFFFFF, carry_out=1, overflow=0.
3. Subtract:
   - a=5, b=7 → sum=0xFFFFFFFE, carry_out=0, overflow=0.
   - a=0x80000000, b=1 → sum=0x7FFFFFFF, carry_out=1, overflow=1.
   - a=b=0x1234 → zero=1, carry_out=1.
4. Handshake:
   - Pulse start again during RUN with different operands → ignored; first result correct; exactly one done.
   - Hold start=1 in the DONE cycle → second operation starts with no IDLE cycle; done pulses spaced N+1=5 cycles apart.
5. Drop rst_n during slice 2 → busy=0, done=0, sum=0, zero=1 immediately (asynchronously). No done follows. A subsequent start completes normally.
6. Parameter sweep:
   - WIDTH=16, CHUNK=4: 0x7FFF+0x0001 → sum=0x8000, overflow=1, latency 4.
   - WIDTH=16, CHUNK=16: same operation with latency 1.
   - Compare randomized results against a behavioural a±b model.
